// File: rtl/nibble_loop_sequencer_pkg.sv
// nibble_loop_sequencer_pkg: shared types for the nibble-loop sequencer.
// Holds the sequencer state enum, the default watchdog limit and the ALU
// command/control types that the sequencer hands to the nibble loop.
package nibble_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } seq_state_t;

  localparam int SEQ_TIMEOUT_DEFAULT = 20;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_AND   = 3'd1,
    CMD_OR    = 3'd2,
    CMD_XOR   = 3'd3,
    CMD_RSHFT = 3'd4
  } AluCmd;

  typedef struct packed {
    AluCmd cmd;
    logic  carry_disable;
    logic  carry_in;
  } AluCtrl;

  // Bitwise ops never propagate a carry between nibbles.
  function automatic logic carry_disable_for(AluCmd cmd);
    return cmd inside {CMD_AND, CMD_OR, CMD_XOR};
  endfunction

  // Sign bit of an operand that is (nib+1)*4 bits wide.
  function automatic logic sign_bit_of(logic [31:0] w, logic [2:0] nib);
    return w[{nib, 2'b11}];
  endfunction

endpackage

// File: rtl/nibble_loop_sequencer_if.sv
// nibble_loop_sequencer_if: request/response handshake bundle between the
// execute stage (master) and the nibble-loop sequencer (slave).
interface nibble_loop_sequencer_if;
  import nibble_loop_sequencer_pkg::*;

  logic        req_valid;
  logic        req_ready;
  AluCmd       req_cmd;
  logic [2:0]  req_nibbles;
  logic        req_signed;
  logic [31:0] req_w1;
  logic [31:0] req_w2;
  logic [31:0] req_preinit;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;

  modport master (
    output req_valid, req_cmd, req_nibbles, req_signed, req_w1, req_w2, req_preinit,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_nibbles, req_signed, req_w1, req_w2, req_preinit,
    output req_ready,
    output rsp_valid, rsp_result, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/nibble_seq_watchdog.sv
// nibble_seq_watchdog: counts RUN cycles of the sequencer and flags the cycle
// in which the limit is reached. Only built with NIBBLE_SEQ_TIMEOUT_EN.
`ifdef NIBBLE_SEQ_TIMEOUT_EN
module nibble_seq_watchdog
  import nibble_loop_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [4:0] run_count;

  // Count RUN cycles since the last ARM; saturate so a stuck loop cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count <= '0;
    end else if (clear) begin
      run_count <= '0;
    end else if (run && run_count != 5'h1f) begin
      run_count <= run_count + 5'd1;
    end
  end

  assign expired = run && (run_count == 5'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/nibble_loop_sequencer.sv
// nibble_loop_sequencer: accepts one ALU op, latches its operands, arms the
// nibble-serial loop, waits for it to finish and returns the result.
// Define NIBBLE_SEQ_TIMEOUT_EN to add a watchdog that aborts a stuck loop.
module nibble_loop_sequencer
  import nibble_loop_sequencer_pkg::*;
`ifdef NIBBLE_SEQ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
)
`endif
(
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_loop_sequencer_if.slave  bus,
  output logic                    loop_perm_to_count,
  output logic [2:0]              loop_nibbles_number,
  output AluCtrl                  ctrl,
  output logic                    word2_is_negative,
  output logic [31:0]             word1,
  output logic [31:0]             word2,
  output logic [31:0]             preinit_result,
  input  logic                    loop_busy,
  input  logic [31:0]             loop_result
);

  seq_state_t state, state_next;
  logic       first_run;
  logic       accept;
  logic       loop_done;
  logic       timeout_abort;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign accept        = bus.req_valid && (state == IDLE);
  // The loop only reports a meaningful busy from the second RUN cycle on.
  assign loop_done     = (state == RUN) && !first_run && !loop_busy;

`ifdef NIBBLE_SEQ_TIMEOUT_EN
  logic wd_expired;

  nibble_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ARM),
    .run     (state == RUN),
    .expired (wd_expired)
  );

  assign timeout_abort = wd_expired && loop_busy;

  // Error flag: cleared by each new op, set when the watchdog aborts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_err <= 1'b0;
    end else if (accept) begin
      bus.rsp_err <= 1'b0;
    end else if (timeout_abort) begin
      bus.rsp_err <= 1'b1;
    end
  end
`else
  assign timeout_abort = 1'b0;
  assign bus.rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and loop permission; the loop is held in preinit outside RUN/DONE
  // and is also released back to preinit when the watchdog gives up on it.
  always_comb begin
    state_next         = state;
    loop_perm_to_count = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) state_next = ARM;
      end
      ARM: begin
        state_next = RUN;
      end
      RUN: begin
        loop_perm_to_count = !timeout_abort;
        if (loop_done || timeout_abort) state_next = DONE;
      end
      DONE: begin
        loop_perm_to_count = !bus.rsp_err;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/control latch at accept (so they are valid throughout ARM) and
  // result capture at loop completion or abort. The loop drives its own carry
  // once counting; the sequencer only ever presents carry_in = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_run           <= 1'b0;
      word1               <= '0;
      word2               <= '0;
      preinit_result      <= '0;
      loop_nibbles_number <= '0;
      word2_is_negative   <= 1'b0;
      ctrl                <= '0;
      bus.rsp_result      <= '0;
    end else begin
      first_run <= (state == ARM);
      if (accept) begin
        word1               <= bus.req_w1;
        word2               <= bus.req_w2;
        preinit_result      <= bus.req_preinit;
        loop_nibbles_number <= bus.req_nibbles;
        word2_is_negative   <= bus.req_signed && sign_bit_of(bus.req_w2, bus.req_nibbles);
        ctrl.cmd            <= bus.req_cmd;
        ctrl.carry_disable  <= carry_disable_for(bus.req_cmd);
        ctrl.carry_in       <= 1'b0;
      end
      if (loop_done) begin
        bus.rsp_result <= loop_result;
      end else if (timeout_abort) begin
        bus.rsp_result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_loop_sequencer.sv
// tb_nibble_loop_sequencer: drives the sequencer against a nibble-serial loop
// stand-in and checks every cycle against an arithmetic reference model.
// The watchdog scenario is only exercised when NIBBLE_SEQ_TIMEOUT_EN is defined.
module tb_nibble_loop_sequencer;
  import nibble_loop_sequencer_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        loop_perm_to_count;
  logic [2:0]  loop_nibbles_number;
  AluCtrl      ctrl;
  logic        word2_is_negative;
  logic [31:0] word1, word2, preinit_result;
  logic        loop_busy;
  logic [31:0] loop_result;

  int n_checks = 0;
  int n_pass   = 0;
  bit stub_stall = 1'b0;

  nibble_loop_sequencer_if bus();

  nibble_loop_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .bus                 (bus),
    .loop_perm_to_count  (loop_perm_to_count),
    .loop_nibbles_number (loop_nibbles_number),
    .ctrl                (ctrl),
    .word2_is_negative   (word2_is_negative),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit_result),
    .loop_busy           (loop_busy),
    .loop_result         (loop_result)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Nibble-serial loop stand-in: reloads preinit while not permitted to count,
  // then processes one nibble per cycle; busy lags one cycle behind the count.
  logic [3:0]  stub_cnt;
  logic        stub_carry, stub_busy_q;
  logic [31:0] stub_acc;
  logic [3:0]  nib_res;
  logic        nib_cout;
  logic [32:0] w2_ext;
  int          nib_idx;

  always_comb begin
    nib_idx  = 4 * int'(stub_cnt[2:0]);
    w2_ext   = {1'b0, word2};
    nib_res  = '0;
    nib_cout = 1'b0;
    case (ctrl.cmd)
      CMD_ADD:   {nib_cout, nib_res} = {1'b0, word1[nib_idx +: 4]} + {1'b0, word2[nib_idx +: 4]}
                                       + {4'b0, stub_carry};
      CMD_AND:   nib_res = word1[nib_idx +: 4] & word2[nib_idx +: 4];
      CMD_OR:    nib_res = word1[nib_idx +: 4] | word2[nib_idx +: 4];
      CMD_XOR:   nib_res = word1[nib_idx +: 4] ^ word2[nib_idx +: 4];
      CMD_RSHFT: nib_res = {(stub_cnt[2:0] == loop_nibbles_number) ? word2_is_negative
                                                                   : w2_ext[nib_idx + 4],
                            w2_ext[nib_idx + 1 +: 3]};
      default:   nib_res = '0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt    <= '0;
      stub_carry  <= 1'b0;
      stub_acc    <= '0;
      stub_busy_q <= 1'b0;
    end else if (!loop_perm_to_count) begin
      stub_cnt    <= '0;
      stub_carry  <= ctrl.carry_in;
      stub_acc    <= preinit_result;
      stub_busy_q <= 1'b0;
    end else if (stub_cnt <= {1'b0, loop_nibbles_number}) begin
      stub_acc[nib_idx +: 4] <= nib_res;
      stub_carry             <= nib_cout;
      stub_cnt               <= stub_cnt + 4'd1;
      stub_busy_q            <= (stub_cnt < {1'b0, loop_nibbles_number});
    end else begin
      stub_busy_q <= 1'b0;
    end
  end

  assign loop_busy   = stub_busy_q | stub_stall;
  assign loop_result = stub_acc;

  // Whole-word reference: operate on the low (nib+1)*4 bits, keep preinit above.
  function automatic logic [31:0] ref_result(AluCmd cmd, int nib, logic sgn,
                                             logic [31:0] w1, logic [31:0] w2, logic [31:0] pre);
    int          width;
    logic [31:0] mask, low;
    logic        neg;
    width = 4 * (nib + 1);
    mask  = 32'((64'h1 << width) - 64'h1);
    neg   = sgn && w2[width - 1];
    case (cmd)
      CMD_ADD:   low = w1 + w2;
      CMD_AND:   low = w1 & w2;
      CMD_OR:    low = w1 | w2;
      CMD_XOR:   low = w1 ^ w2;
      CMD_RSHFT: low = ((w2 & mask) >> 1) | (neg ? (32'h1 << (width - 1)) : 32'h0);
      default:   low = '0;
    endcase
    return (pre & ~mask) | (low & mask);
  endfunction

  // Model of one op in flight: m_age counts cycles since accept (0 = arming),
  // m_len is the number of counting cycles, response is due after that.
  bit          m_busy = 1'b0;
  bit          m_err  = 1'b0;
  int          m_age  = 0;
  int          m_len  = 0;
  int          m_nib  = 0;
  AluCmd       m_cmd  = CMD_ADD;
  logic        m_neg  = 1'b0;
  logic [31:0] m_w1 = '0, m_w2 = '0, m_pre = '0, m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy   <= 1'b1;
        m_age    <= 0;
        m_cmd    <= bus.req_cmd;
        m_nib    <= int'(bus.req_nibbles);
        m_w1     <= bus.req_w1;
        m_w2     <= bus.req_w2;
        m_pre    <= bus.req_preinit;
        m_neg    <= bus.req_signed && bus.req_w2[4 * int'(bus.req_nibbles) + 3];
        m_err    <= stub_stall;
        m_len    <= stub_stall ? 20 : int'(bus.req_nibbles) + 2;
        m_result <= stub_stall ? 32'h0
                  : ref_result(bus.req_cmd, int'(bus.req_nibbles), bus.req_signed,
                               bus.req_w1, bus.req_w2, bus.req_preinit);
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age > m_len && bus.rsp_ready) m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check_output("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      check_output("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_age > m_len));
      check_output("perm_to_count", 32'(loop_perm_to_count),
                   32'(m_busy && m_age >= 1 && (!m_err || m_age < m_len)));
      if (m_busy) begin
        check_output("word1", word1, m_w1);
        check_output("word2", word2, m_w2);
        check_output("preinit", preinit_result, m_pre);
        check_output("nibbles", 32'(loop_nibbles_number), 32'(m_nib));
        check_output("w2_negative", 32'(word2_is_negative), 32'(m_neg));
        check_output("ctrl_cmd", 32'(ctrl.cmd), 32'(m_cmd));
        check_output("ctrl_carry_in", 32'(ctrl.carry_in), 32'h0);
        check_output("ctrl_carry_dis", 32'(ctrl.carry_disable),
                     32'(m_cmd == CMD_AND || m_cmd == CMD_OR || m_cmd == CMD_XOR));
      end
      if (m_busy && m_age > m_len) begin
        check_output("rsp_result", bus.rsp_result, m_result);
        check_output("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
    end
  end

  task automatic apply_stimulus(AluCmd cmd, int nib, logic sgn,
                                logic [31:0] w1, logic [31:0] w2, logic [31:0] pre);
    for (int i = 0; i < 50 && !bus.req_ready; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid   = 1'b1;
    bus.req_cmd     = cmd;
    bus.req_nibbles = 3'(nib);
    bus.req_signed  = sgn;
    bus.req_w1      = w1;
    bus.req_w2      = w2;
    bus.req_preinit = pre;
    @(posedge clk); #1;
    bus.req_valid   = 1'b0;
    bus.req_cmd     = AluCmd'(3'($urandom_range(0, 4)));
    bus.req_nibbles = 3'($urandom_range(0, 7));
    bus.req_signed  = 1'($urandom_range(0, 1));
    bus.req_w1      = $urandom;
    bus.req_w2      = $urandom;
    bus.req_preinit = $urandom;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("rsp_valid_wait", 32'(bus.rsp_valid), 32'h1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bus.req_valid   = 1'b0;
    bus.req_cmd     = CMD_ADD;
    bus.req_nibbles = '0;
    bus.req_signed  = 1'b0;
    bus.req_w1      = '0;
    bus.req_w2      = '0;
    bus.req_preinit = '0;
    bus.rsp_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check_output("rst_rsp_result", bus.rsp_result, 32'h0);
    check_output("rst_perm", 32'(loop_perm_to_count), 32'h0);
    check_output("rst_word1", word1, 32'h0);
    check_output("rst_word2", word2, 32'h0);
    check_output("rst_preinit", preinit_result, 32'h0);
    check_output("rst_ctrl", 32'(ctrl), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 32-bit ADD with a long carry chain.
    apply_stimulus(CMD_ADD, 7, 1'b0, 32'h0eff_ffff, 32'h1, 32'h0);
    wait_rsp(lat);
    check_output("add32_latency", 32'(lat), 32'd11);
    check_output("add32_result", bus.rsp_result, 32'h0f00_0000);
    check_output("add32_err", 32'(bus.rsp_err), 32'h0);
    take_rsp();

    // Signed 8-bit ADD, upper bits from preinit.
    apply_stimulus(CMD_ADD, 1, 1'b1, 32'h0000_ffff, 32'h0000_00ff, 32'h0000_ff00);
    check_output("add8_negative", 32'(word2_is_negative), 32'h1);
    wait_rsp(lat);
    check_output("add8_latency", 32'(lat), 32'd5);
    check_output("add8_result", bus.rsp_result, 32'h0000_fffe);
    take_rsp();

    // Right shift across nibble boundaries.
    apply_stimulus(CMD_RSHFT, 7, 1'b0, 32'h0, 32'h0600_0000, 32'h0);
    wait_rsp(lat);
    check_output("rshft_result", bus.rsp_result, 32'h0300_0000);
    take_rsp();

    // Response back-pressure with a pending request.
    apply_stimulus(CMD_ADD, 0, 1'b0, 32'h5, 32'h3, 32'habcd_ef00);
    wait_rsp(lat);
    check_output("add4_latency", 32'(lat), 32'd4);
    bus.req_valid   = 1'b1;
    bus.req_cmd     = CMD_ADD;
    bus.req_nibbles = 3'd1;
    bus.req_signed  = 1'b0;
    bus.req_w1      = 32'h10;
    bus.req_w2      = 32'h20;
    bus.req_preinit = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check_output("hold_rsp_result", bus.rsp_result, 32'habcd_ef08);
      check_output("hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    take_rsp();
    check_output("post_hs_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("post_hs_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_output("next_accept", 32'(bus.req_ready), 32'h0);
    check_output("next_word1", word1, 32'h10);
    wait_rsp(lat);
    check_output("next_result", bus.rsp_result, 32'h30);
    take_rsp();

    // Reset in the middle of a loop run, then a clean op.
    apply_stimulus(CMD_ADD, 7, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_req_ready", 32'(bus.req_ready), 32'h1);
    check_output("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("midrst_perm", 32'(loop_perm_to_count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_stimulus(CMD_AND, 3, 1'b0, 32'hf0f0_1234, 32'hff00_ff0f, 32'h1111_1111);
    wait_rsp(lat);
    check_output("and16_result", bus.rsp_result, 32'h1111_1204);
    take_rsp();

`ifdef NIBBLE_SEQ_TIMEOUT_EN
    // Loop that never finishes: watchdog abort.
    stub_stall = 1'b1;
    apply_stimulus(CMD_ADD, 7, 1'b0, 32'h1, 32'h2, 32'h0);
    wait_rsp(lat);
    check_output("timeout_latency", 32'(lat), 32'd22);
    check_output("timeout_err", 32'(bus.rsp_err), 32'h1);
    check_output("timeout_result", bus.rsp_result, 32'h0);
    check_output("timeout_perm", 32'(loop_perm_to_count), 32'h0);
    take_rsp();
    stub_stall = 1'b0;
`endif

    // Randomized traffic with changing request fields and random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      bus.req_valid   = ($urandom_range(0, 2) == 0);
      bus.req_cmd     = AluCmd'(3'($urandom_range(0, 4)));
      bus.req_nibbles = 3'($urandom_range(0, 7));
      bus.req_signed  = 1'($urandom_range(0, 1));
      bus.req_w1      = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
      bus.req_w2      = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
      bus.req_preinit = $urandom;
      bus.rsp_ready   = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && m_busy; i++) begin
      @(posedge clk); #1;
    end
    check_output("drain_idle", 32'(bus.req_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
